// File: rtl/uart_pkg.sv
// Shared UART definitions: RX/TX state encodings, default oversampling,
// the receiver output bundle and a 2-of-3 majority helper.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;

    // Receiver FSM encodings
    localparam logic [2:0] RX_IDLE         = 3'd0;
    localparam logic [2:0] RX_START_BIT    = 3'd1;
    localparam logic [2:0] RX_RECEIVE_BYTE = 3'd2;
    localparam logic [2:0] RX_STOP_BIT     = 3'd3;
    localparam logic [2:0] RX_DONE         = 3'd4;
    localparam logic [2:0] RX_BREAK        = 3'd5;

    // Transmitter FSM encodings (same baud generator, same numbering scheme)
    localparam logic [2:0] TX_IDLE         = 3'd0;
    localparam logic [2:0] TX_START_BIT    = 3'd1;
    localparam logic [2:0] TX_SEND_BYTE    = 3'd2;
    localparam logic [2:0] TX_STOP_BIT     = 3'd3;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       framing_error;
        logic       overrun_error;
    } uart_rx_out_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Consumer-side handshake of the UART receiver: held byte plus valid/read
// and the two one-clock error pulses.
interface uart_receiver_if;
    logic [7:0] rx_data_p;
    logic       rx_valid_p;
    logic       rx_read_p;
    logic       framing_error_p;
    logic       overrun_error_p;

    modport master (
        output rx_data_p, rx_valid_p, framing_error_p, overrun_error_p,
        input  rx_read_p
    );

    modport slave (
        input  rx_data_p, rx_valid_p, framing_error_p, overrun_error_p,
        output rx_read_p
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the raw serial line (idles high) plus, when
// UART_RX_MAJORITY_VOTE_EN is defined, a 3-tap majority voter over the
// synchronised line sampled on consecutive baud ticks.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic tick_i,
    input  logic rx_i,
    output logic rx_s_o,
    output logic sample_o
);

    logic [1:0] sync_q;

    // Bring the asynchronous line into the clock domain; reset to idle level
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) sync_q <= 2'b11;
        else          sync_q <= {sync_q[0], rx_i};
    end

    assign rx_s_o = sync_q[1];

`ifdef UART_RX_MAJORITY_VOTE_EN
    // hist_q[1]/hist_q[0] hold the two previous tick samples; together with the
    // live value they give taps at SAMPLE_POINT-1, SAMPLE_POINT, SAMPLE_POINT+1
    // when the FSM decides at SAMPLE_POINT+1.
    logic [1:0] hist_q;

    // Record the synchronised line on every baud tick
    always_ff @(posedge clk_i) begin
        if (!rst_n_i)    hist_q <= 2'b11;
        else if (tick_i) hist_q <= {hist_q[0], sync_q[1]};
    end

    assign sample_o = maj3(hist_q[1], hist_q[0], sync_q[1]);
`else
    logic unused_tick;
    assign unused_tick = tick_i;
    assign sample_o    = sync_q[1];
`endif

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first, idle-high line, driven by an external
// oversampling tick. Bytes are held on a valid/read handshake with one-clock
// framing and overrun pulses.
// Optional feature macro: UART_RX_MAJORITY_VOTE_EN (2-of-3 vote per bit,
// decision one tick later than the single-sample build).
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE   = UART_OVERSAMPLE,
    parameter int SAMPLE_POINT = OVERSAMPLE/2 - 1,
    parameter int DATA_BITS    = 8
)(
    input  logic            clk210_p,
    input  logic            reset_n_p,
    input  logic            baud_16_x_p,
    input  logic            rx_p,
    uart_receiver_if.master rx_if
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int DECIDE = SAMPLE_POINT + 1;
`else
    localparam int DECIDE = SAMPLE_POINT;
`endif
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] DECIDE_PT = CNT_W'(DECIDE);
    localparam logic [3:0]       BIT_LAST  = 4'(DATA_BITS - 1);

    logic             rx_s;
    logic             sample;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] tick_q, tick_d, tick_nxt;
    logic [3:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    uart_rx_out_t     out_q, out_d;
    logic             sample_now;

    uart_rx_sync u_sync (
        .clk_i    (clk210_p),
        .rst_n_i  (reset_n_p),
        .tick_i   (baud_16_x_p),
        .rx_i     (rx_p),
        .rx_s_o   (rx_s),
        .sample_o (sample)
    );

    // The tick counter is cleared only on the start edge and then free-runs
    // modulo OVERSAMPLE, so each later decision lands one full bit after the
    // previous one, centred on the bit.
    assign tick_nxt   = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
    assign sample_now = baud_16_x_p && (tick_q == DECIDE_PT);

    // Frame FSM, bit assembly and output handshake next-state
    always_comb begin
        state_d             = state_q;
        tick_d              = tick_q;
        bit_d               = bit_q;
        shift_d             = shift_q;
        out_d               = out_q;
        out_d.framing_error = 1'b0;
        out_d.overrun_error = 1'b0;
        if (rx_if.rx_read_p && out_q.valid) out_d.valid = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_d = RX_START_BIT;
                    tick_d  = '0;
                end
            end
            RX_START_BIT: begin
                if (baud_16_x_p) tick_d = tick_nxt;
                if (sample_now) begin
                    if (!sample) begin
                        state_d = RX_RECEIVE_BYTE;
                        bit_d   = '0;
                        shift_d = '0;
                    end else begin
                        state_d = RX_IDLE;   // glitch, not a start bit
                    end
                end
            end
            RX_RECEIVE_BYTE: begin
                if (baud_16_x_p) tick_d = tick_nxt;
                if (sample_now) begin
                    shift_d[bit_q[2:0]] = sample;
                    bit_d               = bit_q + 4'd1;
                    if (bit_q == BIT_LAST) state_d = RX_STOP_BIT;
                end
            end
            RX_STOP_BIT: begin
                if (baud_16_x_p) tick_d = tick_nxt;
                if (sample_now) begin
                    if (sample) begin
                        state_d = RX_DONE;
                    end else begin
                        out_d.framing_error = 1'b1;
                        state_d             = RX_BREAK;
                    end
                end
            end
            RX_DONE: begin
                // A read in this same clock loses to the new byte
                out_d.data          = shift_q;
                out_d.valid         = 1'b1;
                out_d.overrun_error = out_q.valid && !rx_if.rx_read_p;
                state_d             = RX_IDLE;
            end
            RX_BREAK: begin
                // Wait for the line to recover so a held-low line cannot re-trigger
                if (rx_s) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // State, counters and output registers
    always_ff @(posedge clk210_p) begin
        if (!reset_n_p) begin
            state_q <= RX_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            out_q   <= out_d;
        end
    end

    assign rx_if.rx_data_p       = out_q.data;
    assign rx_if.rx_valid_p      = out_q.valid;
    assign rx_if.framing_error_p = out_q.framing_error;
    assign rx_if.overrun_error_p = out_q.overrun_error;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are generated at the line level,
// a small frame-level model predicts each outcome into a queue, and a monitor
// matches DUT output events against it.
module tb_uart_receiver;

    localparam int OS        = 16;
    localparam int TICK_CLKS = 4;
    localparam int BIT_CLKS  = OS * TICK_CLKS;
    localparam int K_GOOD    = 0;
    localparam int K_OVR     = 1;
    localparam int K_FERR    = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic baud    = 1'b0;
    logic rx      = 1'b1;

    exp_t       sb_q[$];
    int         checks = 0;
    int         passes = 0;
    bit         unread = 1'b0;
    logic [7:0] last_data = 8'h00;

    uart_receiver_if rif();

    uart_receiver #(.OVERSAMPLE(OS)) dut (
        .clk210_p    (clk),
        .reset_n_p   (reset_n),
        .baud_16_x_p (baud),
        .rx_p        (rx),
        .rx_if       (rif)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (TICK_CLKS - 1) @(negedge clk);
            baud = 1'b1;
            @(negedge clk);
            baud = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else             passes++;
    endtask

    task automatic pop(output bit ok, output exp_t e);
        ok = 1'b0;
        e  = '{kind: -1, data: 8'h00};
        if (sb_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_event: got output event expected none (fe=%0b ov=%0b v=%0b d=%0h)",
                     rif.framing_error_p, rif.overrun_error_p, rif.rx_valid_p, rif.rx_data_p);
        end else begin
            e  = sb_q.pop_front();
            ok = 1'b1;
        end
    endtask

    // Monitor: every framing pulse, overrun pulse or valid rise consumes one prediction
    initial begin
        bit   pv;
        bit   ok;
        exp_t e;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (rif.framing_error_p) begin
                    pop(ok, e);
                    if (ok) chk("ferr_kind", e.kind, K_FERR);
                end
                if (rif.overrun_error_p) begin
                    pop(ok, e);
                    if (ok) begin
                        chk("ovr_kind", e.kind, K_OVR);
                        chk("ovr_data", rif.rx_data_p, e.data);
                        chk("ovr_valid", rif.rx_valid_p, 1);
                    end
                end else if (rif.rx_valid_p && !pv) begin
                    pop(ok, e);
                    if (ok) begin
                        chk("good_kind", e.kind, K_GOOD);
                        chk("good_data", rif.rx_data_p, e.data);
                    end
                end
            end
            pv = rif.rx_valid_p;
        end
    end

    // Frame-level prediction: read at frame start drops the pending byte first
    task automatic predict(input logic [7:0] b, input bit stop_ok, input bit rd);
        if (rd) unread = 1'b0;
        if (!stop_ok) begin
            sb_q.push_back('{kind: K_FERR, data: 8'h00});
        end else begin
            sb_q.push_back('{kind: (unread ? K_OVR : K_GOOD), data: b});
            unread    = 1'b1;
            last_data = b;
        end
    endtask

    // Drive one 8N1 frame; optional read pulse in the first clock of the start bit,
    // optional 1-tick inverted glitch inside data bit gbit
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit rd, input int gbit);
        predict(b, stop_ok, rd);
        rx = 1'b0;
        if (rd) begin
            rif.rx_read_p = 1'b1;
            @(negedge clk);
            rif.rx_read_p = 1'b0;
            chk("read_clears_valid", rif.rx_valid_p, 0);
            repeat (BIT_CLKS - 1) @(negedge clk);
        end else begin
            repeat (BIT_CLKS) @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == gbit) begin
                repeat (30) @(negedge clk);
                rx = ~b[i];
                repeat (TICK_CLKS) @(negedge clk);
                rx = b[i];
                repeat (BIT_CLKS - 30 - TICK_CLKS) @(negedge clk);
            end else begin
                repeat (BIT_CLKS) @(negedge clk);
            end
        end
        rx = stop_ok;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic do_read();
        rif.rx_read_p = 1'b1;
        @(negedge clk);
        rif.rx_read_p = 1'b0;
        unread = 1'b0;
        chk("read_clears_valid", rif.rx_valid_p, 0);
    endtask

    task automatic idle(input int clks);
        rx = 1'b1;
        repeat (clks) @(negedge clk);
    endtask

    task automatic summary();
        $display("%0d/%0d checks passed", passes, checks);
    endtask

    initial begin
        #800000;
        checks++;
        $display("FAIL watchdog: got timeout expected finish");
        summary();
        $finish;
    end

    initial begin
        logic [7:0] b;
        bit         ok;
        rif.rx_read_p = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_data", rif.rx_data_p, 0);
        chk("rst_valid", rif.rx_valid_p, 0);
        chk("rst_ferr", rif.framing_error_p, 0);
        chk("rst_ovr", rif.overrun_error_p, 0);
        reset_n = 1'b1;
        idle(BIT_CLKS);

        // basic byte and read handshake
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        chk("t1_valid", rif.rx_valid_p, 1);
        chk("t1_data", rif.rx_data_p, 8'hA5);
        do_read();

        // back-to-back, read at the start of the next frame
        send_frame(8'h55, 1'b1, 1'b0, -1);
        send_frame(8'h0F, 1'b1, 1'b1, -1);
        do_read();
        idle(BIT_CLKS);

        // framing error followed by a long break
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        repeat (40 * BIT_CLKS) @(negedge clk);
        chk("break_valid", rif.rx_valid_p, 0);
        chk("break_data", rif.rx_data_p, last_data);
        idle(2 * BIT_CLKS);

        // overrun
        send_frame(8'h11, 1'b1, 1'b0, -1);
        send_frame(8'h22, 1'b1, 1'b0, -1);
        chk("ovr_hold_data", rif.rx_data_p, 8'h22);
        chk("ovr_hold_valid", rif.rx_valid_p, 1);
        do_read();
        idle(BIT_CLKS);

        // short low glitch on an idle line
        rx = 1'b0;
        repeat (4 * TICK_CLKS) @(negedge clk);
        idle(2 * BIT_CLKS);
        chk("glitch_valid", rif.rx_valid_p, 0);
`ifdef UART_RX_MAJORITY_VOTE_EN
        send_frame(8'h00, 1'b1, 1'b0, 3);
        do_read();
        idle(BIT_CLKS);
`endif

        // reset mid-byte with a byte pending
        send_frame(8'h5A, 1'b1, 1'b0, -1);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (4 * BIT_CLKS) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("mid_rst_data", rif.rx_data_p, 0);
        chk("mid_rst_valid", rif.rx_valid_p, 0);
        chk("mid_rst_ferr", rif.framing_error_p, 0);
        chk("mid_rst_ovr", rif.overrun_error_p, 0);
        unread    = 1'b0;
        last_data = 8'h00;
        sb_q.delete();
        idle(12 * BIT_CLKS);
        send_frame(8'h81, 1'b1, 1'b0, -1);

        // randomized traffic
        for (int n = 0; n < 24; n++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 7) != 0);
            send_frame(b, ok, 1'($urandom_range(0, 1)), -1);
            if (!ok) idle(BIT_CLKS);
            else     idle($urandom_range(0, 20));
        end
        do_read();

        for (int i = 0; i < 4000 && sb_q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", sb_q.size(), 0);
        summary();
        $finish;
    end

endmodule
